// File: rtl/hunger_drive_pkg.sv
// Shared definitions for the hunger drive: state encodings and default tick constants.
package hunger_drive_pkg;

  typedef enum logic [2:0] {
    StSated    = 3'd0,
    StPeckish  = 3'd1,
    StStarving = 3'd2,
    StEating   = 3'd3,
    StCooldown = 3'd4
  } state_e;

  localparam int unsigned DefDebounceTicks = 4;
  localparam int unsigned DefEatTicks      = 8;
  localparam int unsigned DefCooldownTicks = 6;
  localparam int unsigned DefCryPeriod     = 5;
  localparam int unsigned DefCntW          = 4;

endpackage

// File: rtl/hunger_drive_tick_counter.sv
// Saturating tick counter. o_hit flags the enabled tick on which the count reaches Term;
// with Wrap set the counter returns to zero on that tick instead of saturating.
module hunger_drive_tick_counter #(
  parameter int unsigned CntW = 4,
  parameter int unsigned Term = 4,
  parameter bit          Wrap = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_hit
);

  logic [CntW-1:0] r_count;
  logic            w_hit;

  always_comb begin
    w_hit = i_en && !i_clr && (r_count == CntW'(Term - 1));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr || (Wrap && w_hit)) begin
      r_count <= '0;
    end else if (i_en && (r_count != CntW'(Term))) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_hit = w_hit;

endmodule

// File: rtl/hunger_drive.sv
// Hunger behaviour FSM: debounced hunger, eating bouts with cooldown, periodic cry when starving.
// Define HUNGER_DRIVE_GREEDY_EN to keep a bout running through food loss while starving.
module hunger_drive
  import hunger_drive_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = DefDebounceTicks,
  parameter int unsigned EAT_TICKS      = DefEatTicks,
  parameter int unsigned COOLDOWN_TICKS = DefCooldownTicks,
  parameter int unsigned CRY_PERIOD     = DefCryPeriod,
  parameter int unsigned CNT_W          = DefCntW
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       hungry,
  input  logic       starving,
  input  logic       food,
  output logic       eat,
  output logic       cry,
  output logic       distress,
  output logic [2:0] state_o
);

  state_e r_state, w_state_d;
  logic   r_hungry_q, w_hungry_d;
  logic   r_eat, r_cry, r_distress;
  logic   w_eat, w_cry, w_hold;
  logic   w_deb_hit, w_bout_hit, w_cool_hit, w_cry_hit;

  hunger_drive_tick_counter #(.CntW(CNT_W), .Term(DEBOUNCE_TICKS), .Wrap(1'b1)) u_debounce (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_clr  (hungry == r_hungry_q),
    .i_en   (tick),
    .o_hit  (w_deb_hit)
  );

  // The entry tick is bout tick 1, so the in-state counter terminates one short.
  hunger_drive_tick_counter #(.CntW(CNT_W), .Term(EAT_TICKS - 1), .Wrap(1'b0)) u_bout (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_clr  (r_state != StEating),
    .i_en   (tick),
    .o_hit  (w_bout_hit)
  );

  hunger_drive_tick_counter #(.CntW(CNT_W), .Term(COOLDOWN_TICKS), .Wrap(1'b0)) u_cooldown (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_clr  (r_state != StCooldown),
    .i_en   (tick),
    .o_hit  (w_cool_hit)
  );

  hunger_drive_tick_counter #(.CntW(CNT_W), .Term(CRY_PERIOD), .Wrap(1'b1)) u_cry (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_clr  (r_state != StStarving),
    .i_en   (tick),
    .o_hit  (w_cry_hit)
  );

  // The FSM acts on the debounced value as it stands after this tick.
  assign w_hungry_d = w_deb_hit ? hungry : r_hungry_q;

`ifdef HUNGER_DRIVE_GREEDY_EN
  assign w_hold = starving;
`else
  assign w_hold = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state;
    w_eat     = 1'b0;
    w_cry     = 1'b0;
    case (r_state)
      StSated: begin
        if (tick && w_hungry_d) w_state_d = StPeckish;
      end
      StPeckish: begin
        if (tick) begin
          if (food) begin
            w_state_d = StEating;
            w_eat     = 1'b1;
          end else if (starving) begin
            w_state_d = StStarving;
          end else if (!w_hungry_d) begin
            w_state_d = StSated;
          end
        end
      end
      StStarving: begin
        if (tick) begin
          if (food) begin
            w_state_d = StEating;
            w_eat     = 1'b1;
          end else if (!starving) begin
            w_state_d = StPeckish;
          end else begin
            w_cry = w_cry_hit;
          end
        end
      end
      StEating: begin
        if (tick) begin
          if (!w_hungry_d || (!food && !w_hold)) begin
            w_state_d = StCooldown;
          end else begin
            w_eat = food;
            if (w_bout_hit) w_state_d = StCooldown;
          end
        end
      end
      StCooldown: begin
        if (tick && w_cool_hit) begin
          if (starving)        w_state_d = StStarving;
          else if (w_hungry_d) w_state_d = StPeckish;
          else                 w_state_d = StSated;
        end
      end
      default: w_state_d = StSated;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StSated;
      r_hungry_q <= 1'b0;
      r_eat      <= 1'b0;
      r_cry      <= 1'b0;
      r_distress <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_hungry_q <= w_hungry_d;
      r_eat      <= w_eat;
      r_cry      <= w_cry;
      r_distress <= (w_state_d == StStarving);
    end
  end

  assign eat      = r_eat;
  assign cry      = r_cry;
  assign distress = r_distress;
  assign state_o  = r_state;

endmodule

// File: tb/tb_hunger_drive.sv
// Self-checking bench for hunger_drive: directed scenarios plus randomized ticks vs a tick-level model.
module tb_hunger_drive;

  localparam int Deb  = 4;
  localparam int EatT = 8;
  localparam int Cool = 6;
  localparam int CryP = 5;
`ifdef HUNGER_DRIVE_GREEDY_EN
  localparam bit Greedy = 1'b1;
`else
  localparam bit Greedy = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       hungry = 1'b0;
  logic       starving = 1'b0;
  logic       food = 1'b0;
  logic       eat, cry, distress;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  // Reference model: spec-level counts of ticks spent in each situation.
  int m_st, m_deb, m_bout, m_cool, m_starve;
  bit m_hq, m_eat, m_cry;

  logic [2:0] obs_st, idle_st;
  logic       obs_eat, obs_cry, obs_dis, idle_eat, idle_cry;
  logic       pre_eat, pre_cry, pre_dis, post_eat, post_cry, post_dis;
  logic [2:0] post_st;

  always #5 clk = ~clk;

  hunger_drive #(
    .DEBOUNCE_TICKS(Deb),
    .EAT_TICKS     (EatT),
    .COOLDOWN_TICKS(Cool),
    .CRY_PERIOD    (CryP),
    .CNT_W         (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .hungry  (hungry),
    .starving(starving),
    .food    (food),
    .eat     (eat),
    .cry     (cry),
    .distress(distress),
    .state_o (state_o)
  );

  task automatic model_reset();
    m_st = 0; m_deb = 0; m_bout = 0; m_cool = 0; m_starve = 0;
    m_hq = 1'b0; m_eat = 1'b0; m_cry = 1'b0;
  endtask

  task automatic model_step(input bit h, input bit s, input bit f);
    if (h != m_hq) begin
      m_deb++;
      if (m_deb == Deb) begin
        m_hq  = h;
        m_deb = 0;
      end
    end else begin
      m_deb = 0;
    end
    m_eat = 1'b0;
    m_cry = 1'b0;
    case (m_st)
      0: if (m_hq) m_st = 1;
      1: begin
        if (f) begin m_st = 3; m_bout = 1; m_eat = 1'b1; end
        else if (s) begin m_st = 2; m_starve = 0; end
        else if (!m_hq) m_st = 0;
      end
      2: begin
        if (f) begin m_st = 3; m_bout = 1; m_eat = 1'b1; end
        else if (!s) m_st = 1;
        else begin
          m_starve++;
          m_cry = (m_starve % CryP) == 0;
        end
      end
      3: begin
        m_bout++;
        if (!m_hq || (!f && !(Greedy && s))) begin
          m_st = 4; m_cool = 0;
        end else begin
          m_eat = f;
          if (m_bout == EatT) begin m_st = 4; m_cool = 0; end
        end
      end
      default: begin
        m_cool++;
        if (m_cool == Cool) begin
          if (s) begin m_st = 2; m_starve = 0; end
          else m_st = m_hq ? 1 : 0;
        end
      end
    endcase
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; tick = 1'b0; hungry = 1'b0; starving = 1'b0; food = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_tick(input bit h, input bit s, input bit f);
    @(negedge clk);
    hungry = h; starving = s; food = f; tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    model_step(h, s, f);
    obs_st = state_o; obs_eat = eat; obs_cry = cry; obs_dis = distress;
    @(posedge clk);
    #1;
    idle_st = state_o; idle_eat = eat; idle_cry = cry;
  endtask

  // Tick, then assert reset asynchronously while the tick's outputs are still showing.
  task automatic tick_then_reset(input bit h, input bit s, input bit f);
    @(negedge clk);
    hungry = h; starving = s; food = f; tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    model_step(h, s, f);
    pre_eat = eat; pre_cry = cry; pre_dis = distress;
    #2;
    rst_n = 1'b0;
    #1;
    post_eat = eat; post_cry = cry; post_dis = distress; post_st = state_o;
    model_reset();
    @(negedge clk);
    hungry = 1'b0; starving = 1'b0; food = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic go_peckish();
    apply_reset();
    repeat (Deb) do_tick(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    checks++;
    if (state_o !== 3'd0 || eat !== 1'b0 || cry !== 1'b0 || distress !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got state=%0d eat=%b cry=%b distress=%b want 0 0 0 0",
               state_o, eat, cry, distress);
    end
    apply_reset();
    @(posedge clk); #1;
    checks++;
    if (state_o !== 3'd0) begin
      errors++; $display("FAIL reset_idle_state: got %0d want 0", state_o);
    end
  endtask

  task automatic test_debounce();
    apply_reset();
    repeat (3) do_tick(1'b1, 1'b0, 1'b0);
    do_tick(1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_st !== 3'd0) begin
      errors++; $display("FAIL debounce_glitch: got state %0d want 0", obs_st);
    end
    for (int i = 1; i <= Deb; i++) begin
      do_tick(1'b1, 1'b0, 1'b0);
      checks++;
      if (obs_st !== ((i == Deb) ? 3'd1 : 3'd0)) begin
        errors++;
        $display("FAIL debounce_rise tick %0d: got state %0d want %0d", i, obs_st,
                 (i == Deb) ? 1 : 0);
      end
    end
  endtask

  task automatic test_eat_bout();
    int n_eat;
    go_peckish();
    n_eat = 0;
    for (int i = 1; i <= EatT; i++) begin
      do_tick(1'b1, 1'b0, 1'b1);
      n_eat += int'(obs_eat);
      checks++;
      if (obs_st !== ((i == EatT) ? 3'd4 : 3'd3) || idle_eat !== 1'b0) begin
        errors++;
        $display("FAIL bout_tick %0d: got state %0d idle_eat %b want %0d 0", i, obs_st,
                 idle_eat, (i == EatT) ? 4 : 3);
      end
    end
    checks++;
    if (n_eat != EatT) begin
      errors++; $display("FAIL bout_eat_count: got %0d want %0d", n_eat, EatT);
    end
    for (int i = 1; i <= Cool; i++) begin
      do_tick(1'b0, 1'b0, 1'b0);
      checks++;
      if (obs_st !== ((i == Cool) ? 3'd0 : 3'd4)) begin
        errors++;
        $display("FAIL cooldown_tick %0d: got state %0d want %0d", i, obs_st,
                 (i == Cool) ? 0 : 4);
      end
    end
  endtask

  task automatic test_starving();
    int n_cry;
    go_peckish();
    do_tick(1'b1, 1'b1, 1'b0);
    checks++;
    if (obs_st !== 3'd2 || obs_dis !== 1'b1) begin
      errors++; $display("FAIL starve_entry: got state %0d distress %b want 2 1", obs_st, obs_dis);
    end
    n_cry = 0;
    for (int k = 1; k <= 3 * CryP; k++) begin
      do_tick(1'b1, 1'b1, 1'b0);
      n_cry += int'(obs_cry);
      checks++;
      if (obs_cry !== ((k % CryP) == 0) || idle_cry !== 1'b0 || obs_dis !== 1'b1) begin
        errors++;
        $display("FAIL cry_tick %0d: got cry %b idle_cry %b distress %b want %b 0 1", k, obs_cry,
                 idle_cry, obs_dis, (k % CryP) == 0);
      end
    end
    checks++;
    if (n_cry != 3) begin
      errors++; $display("FAIL cry_count: got %0d want 3", n_cry);
    end
    do_tick(1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_st !== 3'd1 || obs_dis !== 1'b0) begin
      errors++; $display("FAIL starve_exit: got state %0d distress %b want 1 0", obs_st, obs_dis);
    end
    n_cry = 0;
    repeat (2 * CryP) begin
      do_tick(1'b1, 1'b0, 1'b0);
      n_cry += int'(obs_cry);
    end
    checks++;
    if (n_cry != 0) begin
      errors++; $display("FAIL cry_after_exit: got %0d cries want 0", n_cry);
    end
  endtask

  task automatic test_starve_food();
    go_peckish();
    repeat (3) do_tick(1'b1, 1'b1, 1'b0);
    do_tick(1'b1, 1'b1, 1'b1);
    checks++;
    if (obs_st !== 3'd3 || obs_eat !== 1'b1 || obs_dis !== 1'b0) begin
      errors++;
      $display("FAIL starve_food: got state %0d eat %b distress %b want 3 1 0", obs_st, obs_eat,
               obs_dis);
    end
  endtask

  task automatic test_food_drop();
    logic [7:0] pat;
    int n_eat;
    // Plain drop with starving low: exit after three eats.
    go_peckish();
    n_eat = 0;
    repeat (3) begin
      do_tick(1'b1, 1'b0, 1'b1);
      n_eat += int'(obs_eat);
    end
    do_tick(1'b1, 1'b0, 1'b0);
    n_eat += int'(obs_eat);
    checks++;
    if (obs_st !== 3'd4 || n_eat != 3) begin
      errors++; $display("FAIL food_drop: got state %0d eats %0d want 4 3", obs_st, n_eat);
    end
    // Drop while starving: greedy builds keep eating whenever food returns.
    pat = 8'b1010_0111;
    go_peckish();
    n_eat = 0;
    for (int i = 0; i < EatT; i++) begin
      do_tick(1'b1, 1'b1, pat[i]);
      n_eat += int'(obs_eat);
      if (i == 3) begin
        checks++;
        if (obs_st !== (Greedy ? 3'd3 : 3'd4)) begin
          errors++;
          $display("FAIL greedy_hold: got state %0d want %0d", obs_st, Greedy ? 3 : 4);
        end
      end
    end
    checks++;
    if (obs_st !== 3'd4 || n_eat != (Greedy ? 5 : 3)) begin
      errors++;
      $display("FAIL greedy_bout: got state %0d eats %0d want 4 %0d", obs_st, n_eat,
               Greedy ? 5 : 3);
    end
  endtask

  task automatic test_async_reset();
    go_peckish();
    do_tick(1'b1, 1'b0, 1'b1);
    tick_then_reset(1'b1, 1'b0, 1'b1);
    checks++;
    if (pre_eat !== 1'b1 || post_eat !== 1'b0 || post_st !== 3'd0) begin
      errors++;
      $display("FAIL areset_eating: got pre_eat %b post_eat %b state %0d want 1 0 0", pre_eat,
               post_eat, post_st);
    end
    go_peckish();
    repeat (CryP) do_tick(1'b1, 1'b1, 1'b0);
    tick_then_reset(1'b1, 1'b1, 1'b0);
    checks++;
    if (pre_cry !== 1'b1 || pre_dis !== 1'b1 || post_cry !== 1'b0 || post_dis !== 1'b0 ||
        post_st !== 3'd0) begin
      errors++;
      $display("FAIL areset_starving: got pre %b%b post %b%b state %0d want 11 00 0", pre_cry,
               pre_dis, post_cry, post_dis, post_st);
    end
  endtask

  task automatic test_random();
    bit h, s, f;
    apply_reset();
    h = 1'b0; s = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) h = ~h;
      if ($urandom_range(0, 7) == 0) s = ~s;
      f = ($urandom_range(0, 3) != 0);
      do_tick(h, s, f);
      checks++;
      if (obs_st !== 3'(m_st) || obs_eat !== m_eat || obs_cry !== m_cry ||
          obs_dis !== (m_st == 2)) begin
        errors++;
        $display("FAIL rand_tick %0d: got st=%0d eat=%b cry=%b dis=%b want %0d %b %b %b", i,
                 obs_st, obs_eat, obs_cry, obs_dis, m_st, m_eat, m_cry, m_st == 2);
      end
      checks++;
      if (idle_st !== 3'(m_st) || idle_eat !== 1'b0 || idle_cry !== 1'b0) begin
        errors++;
        $display("FAIL rand_idle %0d: got st=%0d eat=%b cry=%b want %0d 0 0", i, idle_st,
                 idle_eat, idle_cry, m_st);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_debounce();
    test_eat_bout();
    test_starving();
    test_starve_food();
    test_food_drop();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hunger_drive.md
Name: hunger_drive

Overview:
Downstream consumer of the nourishment stage's hungry/starving flags. Turns the glucose-derived levels into behaviour: a debounced hunger state machine that asserts an eat action when food is presented, and a periodic distress cry while starving. The eat output is fed back into the action bus, closing the nourishment loop. All timing runs on a slow `tick` enable, not raw clocks.

Parameters:
- DEBOUNCE_TICKS, 4: consecutive ticks `hungry` must be stable before the FSM honours a rise or fall.
- EAT_TICKS, 8: maximum length of one eating bout, in ticks.
- COOLDOWN_TICKS, 6: refractory ticks after a bout during which eating cannot restart.
- CRY_PERIOD, 5: ticks between cry pulses while starving.
- CNT_W, 4: width of the internal tick counters. It must hold the largest of the tick parameters above.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- tick  in  1  one-cycle time-base enable.
- hungry  in  1  level from the nourishment stage.
- starving  in  1  level from the nourishment stage.
- food  in  1  food-present stimulus bit.
- eat  out  1  registered; high for one clk on each tick of an eating bout.
- cry  out  1  registered; one-clk pulse.
- distress  out  1  registered; level, high in STARVING.
- state_o  out  3  registered current state encoding.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=SATED; all counters=0; eat=cry=distress=0; the debounced hungry value hungry_q=0.
  - Reset taking effect mid-bout aborts the bout immediately.
- Debounce:
  - A counter advances on tick while hungry != hungry_q, and clears otherwise.
  - When the counter reaches DEBOUNCE_TICKS, hungry_q takes the value of hungry and the counter clears.
  - `starving` is not debounced.
- States and transitions (all evaluated only on tick cycles unless noted):
  - SATED(0) -> PECKISH when hungry_q=1.
  - PECKISH(1):
    - -> EATING if food=1.
    - -> STARVING if starving=1. Food wins when both food and starving are high.
    - -> SATED if hungry_q=0.
  - STARVING(2):
    - -> EATING if food=1.
    - -> PECKISH if starving=0.
    - distress=1 while in this state.
  - EATING(3):
    - eat=1 on each tick in this state.
    - -> COOLDOWN when the bout counter reaches EAT_TICKS, or when food=0, or when hungry_q=0 (sated).
  - COOLDOWN(4):
    - Ignores food.
    - -> SATED after COOLDOWN_TICKS ticks if hungry_q=0; otherwise -> PECKISH.
    - starving=1 during COOLDOWN: stay in COOLDOWN until it expires, then go to STARVING.
- Latency:
  - A transition is registered on the tick cycle; state_o updates on the next clk edge.
  - eat is asserted in the same clk as the tick that keeps or enters EATING. Entry from a food tick produces eat on that tick.
- Cry:
  - In STARVING, a cry counter advances per tick; on wrap at CRY_PERIOD, cry=1 for one clk.
  - The first cry comes CRY_PERIOD ticks after entering STARVING.
  - The counter clears on exit from STARVING.
- Counters saturate and never wrap past their terminal value. With tick=0, all state holds.
- Unused encodings 5-7 return to SATED on the next clk.

Optional Feature:
- Macro HUNGER_DRIVE_GREEDY_EN.
- Defined:
  - In EATING, the food=0 exit is suppressed while starving=1. The bout then runs the full EAT_TICKS even if food disappears.
  - eat still asserts only when food=1 on that tick.
- Undefined: behaviour exactly as in Behaviour.

Decomposition:
- Shared include `hunger_defs.vh` holds:
  - the state encodings SATED..COOLDOWN;
  - the default tick constants.
- One natural sub-module: `tick_counter`, a CNT_W-wide counter with clear, tick-enable, saturating terminal compare and done flag. It is instantiated for debounce, bout, cooldown and cry.

Test Plan:
- Reset, then hungry=1 held: state_o=1 exactly after the 4th tick; a 3-tick hungry glitch leaves state_o=0.
- PECKISH, food=1 held: eat pulses on 8 consecutive ticks, then state_o=4; after 6 further ticks with hungry=0, state_o=0.
- PECKISH, starving=1, food=0: distress=1; cry pulses at tick 5, 10 and 15 after entry; starving=0 gives state_o=1 and no further cry.
- STARVING plus food=1 on the same tick: goes to EATING, with no STARVING->PECKISH detour and eat=1 that tick.
- EATING, food drops after 3 ticks: COOLDOWN entered with eat count=3. With GREEDY_EN and starving=1, the bout continues to 8 ticks and eat follows food.
- rst_n asserted mid-EATING asynchronously: eat, cry and distress drop to 0 and state_o=0 before the next clk edge.
